// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM states,
// lsunit field positions, funct3 encodings and byte-lane size masks.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } lsu_state_t;

    localparam int LSUNIT_VALID = 4;
    localparam int LSUNIT_STORE = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic funct3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/data for both beats and the
// extracted, extended load result from the two captured read words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic        split,
    output logic [3:0]  strb0,
    output logic [3:0]  strb1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [2:0]  size;
    logic [5:0]  lo_shift;
    logic [5:0]  hi_shift;
    logic [31:0] window;

    assign mask     = size_mask(funct3);
    assign size     = size_bytes(funct3);
    assign split    = ({1'b0, off} + size) > 3'd4;
    assign lo_shift = {1'b0, off, 3'b000};
    assign hi_shift = 6'd32 - lo_shift;

    // A zero offset makes the second-beat shifts reach full width, yielding 0.
    assign strb0  = mask << off;
    assign strb1  = mask >> (3'd4 - {1'b0, off});
    assign wdata0 = wdata << lo_shift;
    assign wdata1 = wdata >> hi_shift;

    assign window = 32'({rdata1, rdata0} >> lo_shift);

    always_comb begin
        load_data = 32'd0;
        case (funct3)
            F3_B:  load_data = {{24{window[7]}}, window[7:0]};
            F3_H:  load_data = {{16{window[15]}}, window[15:0]};
            F3_W:  load_data = window;
            F3_BU: load_data = {24'd0, window[7:0]};
            F3_HU: load_data = {16'd0, window[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: splits misaligned accesses into at most two word
// beats on a req/gnt/rvalid memory port and returns one completion pulse.
module lsu_sequencer
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_lsunit,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_split,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_reg, state_next;
    logic        is_store_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata0_reg;
    logic [31:0] rdata1_reg;
    logic        err_reg;
    logic        noop_reg;
    logic        accept;

    logic        split;
    logic [3:0]  strb0, strb1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] load_data;
    logic [31:0] beat0_addr;

    lsu_align u_align (
        .funct3    (funct3_reg),
        .off       (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .rdata0    (rdata0_reg),
        .rdata1    (rdata1_reg),
        .split     (split),
        .strb0     (strb0),
        .strb1     (strb1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    assign beat0_addr = {addr_reg[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            is_store_reg <= 1'b0;
            funct3_reg   <= 3'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            rdata0_reg   <= 32'd0;
            rdata1_reg   <= 32'd0;
            err_reg      <= 1'b0;
            noop_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                is_store_reg <= req_lsunit[LSUNIT_STORE];
                funct3_reg   <= req_lsunit[2:0];
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                rdata0_reg   <= 32'd0;
                rdata1_reg   <= 32'd0;
                err_reg      <= !funct3_ok(req_lsunit[2:0]);
                noop_reg     <= !req_lsunit[LSUNIT_VALID] || !funct3_ok(req_lsunit[2:0]);
            end
            if (state_reg == WAIT0 && mem_rvalid) rdata0_reg <= mem_rdata;
            if (state_reg == WAIT1 && mem_rvalid) rdata1_reg <= mem_rdata;
        end
    end

    // Outputs decode from registered state only, so they hold still while a beat waits for gnt.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_strb   = 4'b0000;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'd0;
        rsp_err    = 1'b0;
        rsp_split  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (!req_lsunit[LSUNIT_VALID] || !funct3_ok(req_lsunit[2:0]))
                        state_next = DONE;
                    else
                        state_next = REQ0;
                end
            end
            REQ0: begin
                mem_req  = 1'b1;
                mem_we   = is_store_reg;
                mem_addr = beat0_addr;
                if (is_store_reg) begin
                    mem_strb  = strb0;
                    mem_wdata = wdata0;
                end
                if (mem_gnt) begin
                    if (!is_store_reg) state_next = WAIT0;
                    else               state_next = split ? REQ1 : DONE;
                end
            end
            WAIT0: begin
                if (mem_rvalid) state_next = split ? REQ1 : DONE;
            end
            REQ1: begin
                mem_req  = 1'b1;
                mem_we   = is_store_reg;
                mem_addr = beat0_addr + 32'd4;
                if (is_store_reg) begin
                    mem_strb  = strb1;
                    mem_wdata = wdata1;
                end
                if (mem_gnt) state_next = is_store_reg ? DONE : WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) state_next = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_reg;
                rsp_split  = split && !noop_reg;
                rsp_rdata  = (!is_store_reg && !noop_reg) ? load_data : 32'd0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: expected beats and responses are queued
// by the stimulus and checked by an independent monitor against a memory model.
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_lsunit;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_split;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_lsunit (req_lsunit),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_split  (rsp_split),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strb   (mem_strb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        split;
        int          accept_cyc;
        int          lat;
    } rsp_t;

    beat_t       beat_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int gnt_delay = 0;
    bit hold_rvalid = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory model: grants after gnt_delay waiting cycles, returns read data the cycle after gnt.
    initial begin
        bit pend_read;
        int wait_cnt;
        pend_read  = 1'b0;
        wait_cnt   = 0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (pend_read && !hold_rvalid) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0BAD0;
                pend_read  = 1'b0;
            end else if (mem_req && !pend_read) begin
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                end else begin
                    mem_gnt   = 1'b1;
                    wait_cnt  = 0;
                    pend_read = !mem_we;
                end
            end
        end
    end

    // Monitor: every cycle with mem_req is compared against the head beat, so waiting cycles check stability.
    initial begin
        beat_t e;
        rsp_t  r;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (mem_req) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got we=%0b addr=%h strb=%b wdata=%h, required no beat",
                                 mem_we, mem_addr, mem_strb, mem_wdata);
                    end else begin
                        e = beat_q[0];
                        if (mem_we !== e.we || mem_addr !== e.addr || mem_strb !== e.strb ||
                            (e.we && mem_wdata !== e.wdata)) begin
                            errors++;
                            $display("FAIL beat: got we=%0b addr=%h strb=%b wdata=%h, required we=%0b addr=%h strb=%b wdata=%h",
                                     mem_we, mem_addr, mem_strb, mem_wdata, e.we, e.addr, e.strb, e.wdata);
                        end
                        if (mem_gnt) void'(beat_q.pop_front());
                    end
                end
                if (rsp_valid) begin
                    checks++;
                    if (rsp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: got rdata=%h err=%0b split=%0b, required no response",
                                 rsp_rdata, rsp_err, rsp_split);
                    end else begin
                        r = rsp_q.pop_front();
                        if (rsp_rdata !== r.rdata || rsp_err !== r.err || rsp_split !== r.split ||
                            (r.lat > 0 && (cycle - r.accept_cyc) != r.lat)) begin
                            errors++;
                            $display("FAIL rsp: got rdata=%h err=%0b split=%0b lat=%0d, required rdata=%h err=%0b split=%0b lat=%0d",
                                     rsp_rdata, rsp_err, rsp_split, cycle - r.accept_cyc,
                                     r.rdata, r.err, r.split, r.lat);
                        end else begin
                            $display("rsp ok: rdata=%h err=%0b split=%0b lat=%0d",
                                     rsp_rdata, rsp_err, rsp_split, cycle - r.accept_cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata);
        beat_t b;
        b.we = we; b.addr = addr; b.strb = strb; b.wdata = wdata;
        beat_q.push_back(b);
    endtask

    task automatic send(input logic [4:0] lsunit, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input logic exp_split,
                        input int lat);
        rsp_t r;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_lsunit = lsunit;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0, required 1");
        end else begin
            r.rdata = exp_rdata; r.err = exp_err; r.split = exp_split;
            r.accept_cyc = cycle; r.lat = lat;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while ((rsp_q.size() > 0 || beat_q.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() > 0 || beat_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout: got %0d beats %0d rsps pending, required 0",
                     beat_q.size(), rsp_q.size());
            beat_q.delete();
            rsp_q.delete();
        end
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_lsunit = 5'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_mem_req",   {31'd0, mem_req},   32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_addr",  mem_addr,  32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_mem_strb",  {28'd0, mem_strb}, 32'd0);
        chk("reset_mem_we",    {31'd0, mem_we},   32'd0);
        rst_n = 1'b1;

        // LW aligned, minimum latency
        push_beat(1'b0, 32'h0000_0100, 4'b0000, 32'd0);
        rd_q.push_back(32'hDEAD_BEEF);
        send(5'b10010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);

        // LB / LBU at byte 3
        push_beat(1'b0, 32'h0000_0200, 4'b0000, 32'd0);
        rd_q.push_back(32'h8011_2233);
        send(5'b10000, 32'h0000_0203, 32'd0, 32'hFFFF_FF80, 1'b0, 1'b0, 3);
        push_beat(1'b0, 32'h0000_0200, 4'b0000, 32'd0);
        rd_q.push_back(32'h8011_2233);
        send(5'b10100, 32'h0000_0203, 32'd0, 32'h0000_0080, 1'b0, 1'b0, 3);

        // SW split across two words
        push_beat(1'b1, 32'h0000_0100, 4'b1100, 32'hCCDD_0000);
        push_beat(1'b1, 32'h0000_0104, 4'b0011, 32'h0000_AABB);
        send(5'b11010, 32'h0000_0102, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b1, 0);

        // LH at top of address space, second beat wraps to 0
        push_beat(1'b0, 32'hFFFF_FFFC, 4'b0000, 32'd0);
        push_beat(1'b0, 32'h0000_0000, 4'b0000, 32'd0);
        rd_q.push_back(32'h1256_789A);
        rd_q.push_back(32'hAABB_CC34);
        send(5'b10001, 32'hFFFF_FFFF, 32'd0, 32'h0000_3412, 1'b0, 1'b1, 0);

        // Unsupported funct3 and invalid lsunit: no beat, done one cycle after accept
        send(5'b10011, 32'h0000_0400, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        send(5'b01010, 32'h0000_0400, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1);

        // SH with grant withheld 5 cycles: beat held stable
        gnt_delay = 5;
        push_beat(1'b1, 32'h0000_0000, 4'b0110, 32'h00BE_EF00);
        send(5'b11001, 32'h0000_0001, 32'h0000_BEEF, 32'd0, 1'b0, 1'b0, 0);

        // LHU / LH at offset 2
        gnt_delay = 0;
        push_beat(1'b0, 32'h0000_0004, 4'b0000, 32'd0);
        rd_q.push_back(32'h8001_1234);
        send(5'b10101, 32'h0000_0006, 32'd0, 32'h0000_8001, 1'b0, 1'b0, 3);
        gnt_delay = 2;
        push_beat(1'b0, 32'h0000_0004, 4'b0000, 32'd0);
        rd_q.push_back(32'h8001_1234);
        send(5'b10001, 32'h0000_0006, 32'd0, 32'hFFFF_8001, 1'b0, 1'b0, 5);
        gnt_delay = 0;

        // SB into top lane, SH split, LW split
        push_beat(1'b1, 32'h0000_0000, 4'b1000, 32'hA500_0000);
        send(5'b11000, 32'h0000_0003, 32'h1234_56A5, 32'd0, 1'b0, 1'b0, 2);
        push_beat(1'b1, 32'h0001_0000, 4'b1000, 32'hFE00_0000);
        push_beat(1'b1, 32'h0001_0004, 4'b0001, 32'h0000_00CA);
        send(5'b11001, 32'h0001_0003, 32'h0000_CAFE, 32'd0, 1'b0, 1'b1, 3);
        push_beat(1'b0, 32'h0000_0100, 4'b0000, 32'd0);
        push_beat(1'b0, 32'h0000_0104, 4'b0000, 32'd0);
        rd_q.push_back(32'h4433_2211);
        rd_q.push_back(32'h8877_6655);
        send(5'b10010, 32'h0000_0101, 32'd0, 32'h5544_3322, 1'b0, 1'b1, 5);

        // Reset while waiting for read data, then a stale rvalid in IDLE
        hold_rvalid = 1'b1;
        push_beat(1'b0, 32'h0000_0300, 4'b0000, 32'd0);
        rd_q.push_back(32'h5555_AAAA);
        @(negedge clk);
        req_valid  = 1'b1;
        req_lsunit = 5'b10010;
        req_addr   = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (beat_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_beat_granted", beat_q.size(), 32'd0);
        beat_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_rvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post_reset_mem_req",   {31'd0, mem_req},   32'd0);
            chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
